logic_axi4_lite_register_bank: RTL and testbench

//  AXI4-Lite responder (slave end) terminating a master's AW/W/B/AR/R channels in a bank of

---
 rtl/logic_axi4_lite_register_bank_if.sv | 52 +++++
 rtl/logic_axi4_lite_register_bank.sv | 239 +++++++++++++++++++++++
 tb/tb_logic_axi4_lite_register_bank.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_axi4_lite_register_bank_if.sv
// AXI4-Lite bus bundle (AW/W/B/AR/R channels) shared by the register bank and its master.
// The slave modport is the register-bank side; the master modport is the initiator side.
interface logic_axi4_lite_register_bank_if #(
   parameter int DATA_BYTES    = 4,
   parameter int ADDRESS_WIDTH = 8
);
   logic                     awvalid;
   logic                     awready;
   logic [ADDRESS_WIDTH-1:0] awaddr;
   logic [2:0]               awprot;
   logic                     wvalid;
   logic                     wready;
   logic [8*DATA_BYTES-1:0]  wdata;
   logic [DATA_BYTES-1:0]    wstrb;
   logic                     bvalid;
   logic                     bready;
   logic [1:0]               bresp;
   logic                     arvalid;
   logic                     arready;
   logic [ADDRESS_WIDTH-1:0] araddr;
   logic [2:0]               arprot;
   logic                     rvalid;
   logic                     rready;
   logic [8*DATA_BYTES-1:0]  rdata;
   logic [1:0]               rresp;

   modport slave (
      input  awvalid, awaddr, awprot,
      output awready,
      input  wvalid, wdata, wstrb,
      output wready,
      output bvalid, bresp,
      input  bready,
      input  arvalid, araddr, arprot,
      output arready,
      output rvalid, rdata, rresp,
      input  rready
   );

   modport master (
      output awvalid, awaddr, awprot,
      input  awready,
      output wvalid, wdata, wstrb,
      input  wready,
      input  bvalid, bresp,
      output bready,
      output arvalid, araddr, arprot,
      input  arready,
      input  rvalid, rdata, rresp,
      output rready
   );
endinterface

// File: rtl/logic_axi4_lite_register_bank.sv
// AXI4-Lite register bank: terminates AW/W/B/AR/R in REGISTERS software-visible registers,
// exports the register contents and a one-cycle per-register write pulse.
// Optional feature macro: LOGIC_AXI4_LITE_REGISTER_BANK_PROT_CHECK_EN
//   defined   -> accesses with prot[0]=0 (unprivileged) get SLVERR and have no effect.
//   undefined -> awprot/arprot ignored; only the address decode decides the response.
module logic_axi4_lite_register_bank #(
   parameter int DATA_BYTES    = 4,
   parameter int ADDRESS_WIDTH = 8,
   parameter int REGISTERS     = 16
) (
   input  logic                              aclk,
   input  logic                              areset,
   logic_axi4_lite_register_bank_if.slave    bus,
   output logic [REGISTERS*8*DATA_BYTES-1:0] regs,
   output logic [REGISTERS-1:0]              regs_written
);
   localparam int W      = 8 * DATA_BYTES;
   localparam int LSB    = $clog2(DATA_BYTES);
   localparam int IDX_W  = ADDRESS_WIDTH - LSB;
   localparam int RIDX_W = $clog2(REGISTERS);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_COLLECT, W_RESP} wstate_t;
   typedef enum logic {R_IDLE, R_RESP} rstate_t;

   logic [W-1:0] regs_q [REGISTERS];

   wstate_t                  wstate_q, wstate_d;
   logic                     aw_held_q, aw_held_d;
   logic                     w_held_q, w_held_d;
   logic [ADDRESS_WIDTH-1:0] awaddr_q, awaddr_d;
   logic [2:0]               awprot_q, awprot_d;
   logic [W-1:0]             wdata_q, wdata_d;
   logic [DATA_BYTES-1:0]    wstrb_q, wstrb_d;
   logic                     bvalid_q, bvalid_d;
   logic [1:0]               bresp_q, bresp_d;
   logic [REGISTERS-1:0]     regs_written_q, regs_written_d;

   rstate_t                  rstate_q, rstate_d;
   logic                     rvalid_q, rvalid_d;
   logic [1:0]               rresp_q, rresp_d;
   logic [W-1:0]             rdata_q, rdata_d;

   logic [ADDRESS_WIDTH-1:0] wr_addr, rd_addr;
   logic [2:0]               wr_prot, rd_prot;
   logic [W-1:0]             wr_data;
   logic [DATA_BYTES-1:0]    wr_strb;
   logic [IDX_W-1:0]         wr_idx, rd_idx;
   logic                     wr_prot_ok, rd_prot_ok;
   logic                     wr_ok, rd_ok;
   logic                     wr_commit;
   logic                     aw_fire, w_fire, ar_fire;
   logic                     unused_bits;

   // Byte-lane merge of new write data into the old register value.
   function automatic logic [W-1:0] merge_strb(input logic [W-1:0]          old_v,
                                               input logic [W-1:0]          new_v,
                                               input logic [DATA_BYTES-1:0] strb);
      logic [W-1:0] res;
      res = old_v;
      for (int b = 0; b < DATA_BYTES; b++) begin
         if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
      end
      return res;
   endfunction

   function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
      return int'(idx) < REGISTERS;
   endfunction

   // A channel captured in an earlier cycle wins over the live bus value.
   assign wr_addr = aw_held_q ? awaddr_q : bus.awaddr;
   assign wr_prot = aw_held_q ? awprot_q : bus.awprot;
   assign wr_data = w_held_q  ? wdata_q  : bus.wdata;
   assign wr_strb = w_held_q  ? wstrb_q  : bus.wstrb;
   assign wr_idx  = wr_addr[ADDRESS_WIDTH-1:LSB];
   assign rd_addr = bus.araddr;
   assign rd_prot = bus.arprot;
   assign rd_idx  = rd_addr[ADDRESS_WIDTH-1:LSB];

`ifdef LOGIC_AXI4_LITE_REGISTER_BANK_PROT_CHECK_EN
   assign wr_prot_ok = wr_prot[0];
   assign rd_prot_ok = rd_prot[0];
`else
   assign wr_prot_ok = 1'b1;
   assign rd_prot_ok = 1'b1;
`endif

   assign wr_ok = idx_in_range(wr_idx) && wr_prot_ok;
   assign rd_ok = idx_in_range(rd_idx) && rd_prot_ok;

   // Sub-word address bits and (when unchecked) prot carry no meaning for this bank.
   assign unused_bits = ^{wr_addr[LSB-1:0], rd_addr[LSB-1:0], wr_prot, rd_prot};

   // Write FSM: collect AW and W in any order, commit once both are held, hold B until accepted.
   always_comb begin
      wstate_d       = wstate_q;
      aw_held_d      = aw_held_q;
      w_held_d       = w_held_q;
      awaddr_d       = awaddr_q;
      awprot_d       = awprot_q;
      wdata_d        = wdata_q;
      wstrb_d        = wstrb_q;
      bvalid_d       = bvalid_q;
      bresp_d        = bresp_q;
      regs_written_d = '0;
      bus.awready    = 1'b0;
      bus.wready     = 1'b0;
      aw_fire        = 1'b0;
      w_fire         = 1'b0;
      wr_commit      = 1'b0;
      case (wstate_q)
         W_COLLECT: begin
            bus.awready = !areset && !aw_held_q;
            bus.wready  = !areset && !w_held_q;
            aw_fire     = bus.awvalid && bus.awready;
            w_fire      = bus.wvalid && bus.wready;
            if (aw_fire) begin
               aw_held_d = 1'b1;
               awaddr_d  = bus.awaddr;
               awprot_d  = bus.awprot;
            end
            if (w_fire) begin
               w_held_d = 1'b1;
               wdata_d  = bus.wdata;
               wstrb_d  = bus.wstrb;
            end
            if ((aw_held_q || aw_fire) && (w_held_q || w_fire)) begin
               wr_commit = 1'b1;
               bvalid_d  = 1'b1;
               bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
               if (wr_ok) regs_written_d[wr_idx[RIDX_W-1:0]] = 1'b1;
               wstate_d  = W_RESP;
            end
         end
         W_RESP: begin
            if (bus.bready) begin
               bvalid_d  = 1'b0;
               aw_held_d = 1'b0;
               w_held_d  = 1'b0;
               wstate_d  = W_COLLECT;
            end
         end
         default: wstate_d = W_COLLECT;
      endcase
   end

   // Write-side control state; reset drops any pending capture or response.
   always_ff @(posedge aclk) begin
      if (areset) begin
         wstate_q       <= W_COLLECT;
         aw_held_q      <= 1'b0;
         w_held_q       <= 1'b0;
         bvalid_q       <= 1'b0;
         bresp_q        <= RESP_OKAY;
         regs_written_q <= '0;
      end else begin
         wstate_q       <= wstate_d;
         aw_held_q      <= aw_held_d;
         w_held_q       <= w_held_d;
         bvalid_q       <= bvalid_d;
         bresp_q        <= bresp_d;
         regs_written_q <= regs_written_d;
      end
   end

   // Captured AW/W payload; only meaningful while the matching held flag is set.
   always_ff @(posedge aclk) begin
      awaddr_q <= awaddr_d;
      awprot_q <= awprot_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
   end

   // Register bank update on the commit edge.
   always_ff @(posedge aclk) begin
      if (areset) begin
         for (int i = 0; i < REGISTERS; i++) regs_q[i] <= '0;
      end else if (wr_commit && wr_ok) begin
         regs_q[wr_idx[RIDX_W-1:0]] <= merge_strb(regs_q[wr_idx[RIDX_W-1:0]], wr_data, wr_strb);
      end
   end

   // Read FSM: sample the pre-write register value on AR, hold R until accepted.
   always_comb begin
      rstate_d    = rstate_q;
      rvalid_d    = rvalid_q;
      rresp_d     = rresp_q;
      rdata_d     = rdata_q;
      bus.arready = 1'b0;
      ar_fire     = 1'b0;
      case (rstate_q)
         R_IDLE: begin
            bus.arready = !areset;
            ar_fire     = bus.arvalid && bus.arready;
            if (ar_fire) begin
               rvalid_d = 1'b1;
               rresp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
               rdata_d  = rd_ok ? regs_q[rd_idx[RIDX_W-1:0]] : '0;
               rstate_d = R_RESP;
            end
         end
         R_RESP: begin
            if (bus.rready) begin
               rvalid_d = 1'b0;
               rstate_d = R_IDLE;
            end
         end
         default: rstate_d = R_IDLE;
      endcase
   end

   // Read-side state and response payload.
   always_ff @(posedge aclk) begin
      if (areset) begin
         rstate_q <= R_IDLE;
         rvalid_q <= 1'b0;
         rresp_q  <= RESP_OKAY;
         rdata_q  <= '0;
      end else begin
         rstate_q <= rstate_d;
         rvalid_q <= rvalid_d;
         rresp_q  <= rresp_d;
         rdata_q  <= rdata_d;
      end
   end

   assign bus.bvalid   = bvalid_q;
   assign bus.bresp    = bresp_q;
   assign bus.rvalid   = rvalid_q;
   assign bus.rresp    = rresp_q;
   assign bus.rdata    = rdata_q;
   assign regs_written = regs_written_q;

   for (genvar g = 0; g < REGISTERS; g++) begin : g_regs_out
      assign regs[g*W +: W] = regs_q[g];
   end
endmodule

// File: tb/tb_logic_axi4_lite_register_bank.sv
// Directed testbench for logic_axi4_lite_register_bank (16 x 32-bit registers, 8-bit address).
module tb_logic_axi4_lite_register_bank;
   logic           aclk;
   logic           areset;
   logic [511:0]   regs;
   logic [15:0]    regs_written;
   int             n_total;
   int             n_pass;
   int             pulse_cnt;
   int             pc;
   logic [1:0]     resp;
   logic [31:0]    rd;
   logic [511:0]   saved;

   logic_axi4_lite_register_bank_if #(.DATA_BYTES(4), .ADDRESS_WIDTH(8)) bus ();

   logic_axi4_lite_register_bank #(
      .DATA_BYTES(4), .ADDRESS_WIDTH(8), .REGISTERS(16)
   ) dut (
      .aclk(aclk),
      .areset(areset),
      .bus(bus),
      .regs(regs),
      .regs_written(regs_written)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // Count cycles in which any write pulse is visible.
   always @(negedge aclk) begin
      if (regs_written != '0) pulse_cnt <= pulse_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [2:0] p, output logic [1:0] r);
      logic aw_pend, w_pend, aw_hs, w_hs, got;
      aw_pend = 1'b1; w_pend = 1'b1; got = 1'b0; r = 2'b11;
      bus.awaddr = a; bus.awprot = p; bus.wdata = d; bus.wstrb = s;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
      for (int n = 0; n < 20 && (aw_pend || w_pend); n++) begin
         @(negedge aclk);
         aw_hs = bus.awvalid && bus.awready;
         w_hs  = bus.wvalid && bus.wready;
         tick();
         if (aw_hs) begin bus.awvalid = 1'b0; aw_pend = 1'b0; end
         if (w_hs)  begin bus.wvalid  = 1'b0; w_pend  = 1'b0; end
      end
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge aclk);
         if (bus.bvalid) begin r = bus.bresp; got = 1'b1; end
         tick();
      end
      bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
      check_eq("write_done", {61'd0, aw_pend, w_pend, got}, 64'd1);
   endtask

   task automatic axi_read(input logic [7:0] a, input logic [2:0] p,
                           output logic [31:0] d, output logic [1:0] r);
      logic pend, hs, got;
      pend = 1'b1; got = 1'b0; d = 32'hxxxx_xxxx; r = 2'b11;
      bus.araddr = a; bus.arprot = p; bus.arvalid = 1'b1; bus.rready = 1'b1;
      for (int n = 0; n < 20 && pend; n++) begin
         @(negedge aclk);
         hs = bus.arvalid && bus.arready;
         tick();
         if (hs) begin bus.arvalid = 1'b0; pend = 1'b0; end
      end
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge aclk);
         if (bus.rvalid) begin d = bus.rdata; r = bus.rresp; got = 1'b1; end
         tick();
      end
      bus.arvalid = 1'b0; bus.rready = 1'b0;
      check_eq("read_done", {62'd0, pend, got}, 64'd1);
   endtask

   initial begin
      n_total = 0; n_pass = 0; pulse_cnt = 0;
      bus.awvalid = 1'b0; bus.awaddr = '0; bus.awprot = 3'b001;
      bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.bready = 1'b0;
      bus.arvalid = 1'b0; bus.araddr = '0; bus.arprot = 3'b001; bus.rready = 1'b0;
      areset = 1'b1;
      tick(); tick(); tick();

      // Reset state
      check_eq("rst_awready", bus.awready, 0);
      check_eq("rst_wready", bus.wready, 0);
      check_eq("rst_arready", bus.arready, 0);
      check_eq("rst_bvalid", bus.bvalid, 0);
      check_eq("rst_rvalid", bus.rvalid, 0);
      check_eq("rst_regs_zero", regs == '0, 1);
      check_eq("rst_regs_written", regs_written, 0);
      check_eq("rst_rdata", bus.rdata, 0);
      check_eq("rst_resps", {bus.bresp, bus.rresp}, 0);
      areset = 1'b0;
      #1;
      check_eq("post_rst_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);

      // AW and W together to 0x04
      bus.awvalid = 1'b1; bus.awaddr = 8'h04; bus.awprot = 3'b001;
      bus.wvalid = 1'b1; bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF;
      tick();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      check_eq("t1_bvalid", bus.bvalid, 1);
      check_eq("t1_bresp", bus.bresp, 2'b00);
      check_eq("t1_reg1", regs[32 +: 32], 32'hDEADBEEF);
      check_eq("t1_pulse", regs_written, 16'h0002);
      check_eq("t1_ready_resp", {bus.awready, bus.wready}, 0);
      tick();
      check_eq("t1_pulse_once", regs_written, 16'h0000);
      check_eq("t1_bvalid_hold", bus.bvalid, 1);
      bus.bready = 1'b1;
      tick();
      bus.bready = 1'b0;
      check_eq("t1_bvalid_clr", bus.bvalid, 0);
      check_eq("t1_awready_back", bus.awready, 1);

      // Partial strobe write over zero, then read back (also with ignored low address bits)
      axi_write(8'h00, 32'h11223344, 4'b0101, 3'b001, resp);
      check_eq("strb_bresp", resp, 2'b00);
      check_eq("strb_reg0", regs[0 +: 32], 32'h00220044);
      axi_read(8'h00, 3'b001, rd, resp);
      check_eq("strb_rdata", rd, 32'h00220044);
      check_eq("strb_rresp", resp, 2'b00);
      axi_read(8'h03, 3'b001, rd, resp);
      check_eq("lowbits_rdata", rd, 32'h00220044);

      // wstrb = 0 on a valid register: OKAY, unchanged, pulse still issued
      pc = pulse_cnt;
      axi_write(8'h04, 32'hFFFFFFFF, 4'h0, 3'b001, resp);
      check_eq("strb0_bresp", resp, 2'b00);
      check_eq("strb0_reg1", regs[32 +: 32], 32'hDEADBEEF);
      check_eq("strb0_pulse", pulse_cnt - pc, 1);

      // W first, AW three cycles later, B back-pressured for four cycles
      pc = pulse_cnt;
      bus.wvalid = 1'b1; bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'hF;
      tick();
      bus.wvalid = 1'b0;
      check_eq("t2_wready_held", bus.wready, 0);
      check_eq("t2_awready_open", bus.awready, 1);
      check_eq("t2_no_bvalid", bus.bvalid, 0);
      tick(); tick();
      bus.awvalid = 1'b1; bus.awaddr = 8'h00; bus.awprot = 3'b001;
      tick();
      bus.awvalid = 1'b0;
      check_eq("t2_reg0", regs[0 +: 32], 32'hCAFEF00D);
      for (int i = 0; i < 4; i++) begin
         check_eq("t2_bp_bvalid", bus.bvalid, 1);
         check_eq("t2_bp_bresp", bus.bresp, 2'b00);
         check_eq("t2_bp_ready", {bus.awready, bus.wready}, 0);
         tick();
      end
      bus.bready = 1'b1;
      tick();
      bus.bready = 1'b0;
      check_eq("t2_bvalid_clr", bus.bvalid, 0);
      check_eq("t2_pulse_count", pulse_cnt - pc, 1);
      check_eq("t2_reg0_final", regs[0 +: 32], 32'hCAFEF00D);

      // Out-of-range index 16 (0x40) and 63 (0xFC)
      saved = regs;
      pc = pulse_cnt;
      axi_read(8'h40, 3'b001, rd, resp);
      check_eq("oor_rresp", resp, 2'b10);
      check_eq("oor_rdata", rd, 0);
      axi_write(8'h40, 32'h12345678, 4'hF, 3'b001, resp);
      check_eq("oor_bresp", resp, 2'b10);
      axi_write(8'hFC, 32'h87654321, 4'hF, 3'b001, resp);
      check_eq("oor_top_bresp", resp, 2'b10);
      check_eq("oor_regs_same", regs == saved, 1);
      check_eq("oor_no_pulse", pulse_cnt - pc, 0);

      // Same-cycle read and write of reg 2
      axi_write(8'h08, 32'h00000055, 4'hF, 3'b001, resp);
      bus.awvalid = 1'b1; bus.awaddr = 8'h08; bus.wvalid = 1'b1; bus.wdata = 32'h000000AA;
      bus.wstrb = 4'hF; bus.arvalid = 1'b1; bus.araddr = 8'h08; bus.arprot = 3'b001;
      bus.bready = 1'b1; bus.rready = 1'b1;
      tick();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
      check_eq("rw_rvalid", bus.rvalid, 1);
      check_eq("rw_rdata_old", bus.rdata, 32'h00000055);
      check_eq("rw_bvalid", bus.bvalid, 1);
      check_eq("rw_reg2_new", regs[64 +: 32], 32'h000000AA);
      tick();
      bus.bready = 1'b0; bus.rready = 1'b0;
      check_eq("rw_both_clr", {bus.bvalid, bus.rvalid}, 0);
      axi_read(8'h08, 3'b001, rd, resp);
      check_eq("rw_reread", rd, 32'h000000AA);

      // Protection: unprivileged then privileged access to reg 3
      axi_write(8'h0C, 32'h00000077, 4'hF, 3'b000, resp);
      axi_read(8'h0C, 3'b000, rd, saved[31:0]);
`ifdef LOGIC_AXI4_LITE_REGISTER_BANK_PROT_CHECK_EN
      check_eq("prot0_bresp", resp, 2'b10);
      check_eq("prot0_reg3", regs[96 +: 32], 32'h0);
      check_eq("prot0_rresp", saved[1:0], 2'b10);
      check_eq("prot0_rdata", rd, 32'h0);
`else
      check_eq("prot0_bresp", resp, 2'b00);
      check_eq("prot0_reg3", regs[96 +: 32], 32'h77);
      check_eq("prot0_rresp", saved[1:0], 2'b00);
      check_eq("prot0_rdata", rd, 32'h77);
`endif
      axi_write(8'h0C, 32'h00000099, 4'hF, 3'b001, resp);
      check_eq("prot1_bresp", resp, 2'b00);
      check_eq("prot1_reg3", regs[96 +: 32], 32'h99);

      // Reset with both responses pending
      bus.awvalid = 1'b1; bus.awaddr = 8'h10; bus.wvalid = 1'b1; bus.wdata = 32'h1234;
      bus.wstrb = 4'hF; bus.arvalid = 1'b1; bus.araddr = 8'h10;
      tick();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
      check_eq("mid_pending", {bus.bvalid, bus.rvalid}, 2'b11);
      areset = 1'b1;
      tick();
      check_eq("mid_rst_clr", {bus.bvalid, bus.rvalid}, 0);
      check_eq("mid_rst_regs", regs == '0, 1);
      areset = 1'b0;
      bus.bready = 1'b1; bus.rready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("mid_no_resp", {bus.bvalid, bus.rvalid}, 0);
      end
      bus.bready = 1'b0; bus.rready = 1'b0;
      check_eq("mid_ready_back", {bus.awready, bus.wready, bus.arready}, 3'b111);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
